// File: rtl/if_fetch_queue_if.sv
// Fetch->decode queue handshake bundle: fetch-side push, decode-side pop, flush.
interface if_fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready;
  logic [PTR_W:0]   count;

  // Queue side
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  // Pipeline side (fetch/decode/EXE)
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupling FIFO between fetch and decode. Holds {PC, instr} pairs in order,
// freezes fetch only when full, and drops everything on a taken branch.
module if_fetch_queue #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int PTR_W = 2   // log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,   // async, active-low
  if_fetch_queue_if.slave  q
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               push, pop;
  entry_t             head;

  // Flush wins over both handshakes so wrong-path data never lands.
  assign push = q.in_valid  & q.in_ready  & ~q.flush;
  assign pop  = q.out_valid & q.out_ready & ~q.flush;

  // Outputs come from registered state only: no same-cycle bypass.
  assign head        = mem_q[rd_ptr_q];
  assign q.in_ready  = (cnt_q != FULL_CNT);
  assign q.out_valid = (cnt_q != '0);
  assign q.out_pc    = q.out_valid ? head.pc    : 32'd0;  // 0 doubles as NOP
  assign q.out_instr = q.out_valid ? head.instr : 32'd0;
  assign q.count     = cnt_q;

  // Next-state: pointers wrap naturally at PTR_W bits.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (q.flush) begin
      // Storage is left as-is; it is unreachable once cnt is zero.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: q.in_pc, instr: q.in_instr};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; reset clears storage too so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, hand sequences for reset
// and wrap, then random traffic against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_queue_if #(.PTR_W(PTR_W)) qif ();

  if_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;
    int          e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_in_ready;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ord);
    qif.flush     = fl;
    qif.in_valid  = iv;
    qif.in_pc     = pc;
    qif.in_instr  = ins;
    qif.out_ready = ord;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic v,
                           input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    chk({tag, ".count"},     32'(qif.count),     32'(cnt));
    chk({tag, ".out_valid"}, 32'(qif.out_valid), 32'(v));
    chk({tag, ".out_pc"},    qif.out_pc,         pc);
    chk({tag, ".out_instr"}, qif.out_instr,      ins);
    chk({tag, ".in_ready"},  32'(qif.in_ready),  32'(rdy));
  endtask

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic [31:0] ins,
                              logic ord, int ec, logic ev, logic [31:0] ep,
                              logic [31:0] ei, logic er);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_pc = pc; v.in_instr = ins; v.out_ready = ord;
    v.e_count = ec; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_in_ready = er;
    return v;
  endfunction

  // Reference model state: an ordered queue of {pc, instr}.
  logic [63:0] model[$];

  initial begin
    // Expected outputs describe the state seen before the edge that applies the inputs.
    //            fl iv  in_pc     in_instr      ord  cnt v  pc        instr         rdy
    vecs[0]  = mk(0, 1, 32'd4,    32'hE3A01001, 0,   0, 0, 32'd0,    32'd0,        1); // fill
    vecs[1]  = mk(0, 1, 32'd8,    32'hE3A01002, 0,   1, 1, 32'd4,    32'hE3A01001, 1);
    vecs[2]  = mk(0, 1, 32'd12,   32'hE3A01003, 0,   2, 1, 32'd4,    32'hE3A01001, 1);
    vecs[3]  = mk(0, 1, 32'd16,   32'hE3A01004, 0,   3, 1, 32'd4,    32'hE3A01001, 1);
    vecs[4]  = mk(0, 1, 32'd20,   32'hE3A01005, 0,   4, 1, 32'd4,    32'hE3A01001, 0); // ignored
    vecs[5]  = mk(0, 0, 32'd0,    32'd0,        1,   4, 1, 32'd4,    32'hE3A01001, 0); // drain
    vecs[6]  = mk(0, 0, 32'd0,    32'd0,        1,   3, 1, 32'd8,    32'hE3A01002, 1);
    vecs[7]  = mk(0, 0, 32'd0,    32'd0,        1,   2, 1, 32'd12,   32'hE3A01003, 1);
    vecs[8]  = mk(0, 0, 32'd0,    32'd0,        1,   1, 1, 32'd16,   32'hE3A01004, 1);
    vecs[9]  = mk(0, 0, 32'd0,    32'd0,        1,   0, 0, 32'd0,    32'd0,        1); // pop on empty
    vecs[10] = mk(0, 1, 32'h20,   32'hA0,       0,   0, 0, 32'd0,    32'd0,        1);
    vecs[11] = mk(0, 1, 32'h24,   32'hA1,       0,   1, 1, 32'h20,   32'hA0,       1);
    vecs[12] = mk(0, 1, 32'h28,   32'hA2,       0,   2, 1, 32'h20,   32'hA0,       1);
    vecs[13] = mk(1, 1, 32'h100,  32'h1,        1,   3, 1, 32'h20,   32'hA0,       1); // flush
    vecs[14] = mk(0, 1, 32'h200,  32'h2,        0,   0, 0, 32'd0,    32'd0,        1);
    vecs[15] = mk(0, 0, 32'd0,    32'd0,        1,   1, 1, 32'h200,  32'h2,        1);
    vecs[16] = mk(0, 1, 32'h40,   32'h40A,      1,   0, 0, 32'd0,    32'd0,        1); // empty latency
    vecs[17] = mk(0, 0, 32'd0,    32'd0,        1,   1, 1, 32'h40,   32'h40A,      1);
    vecs[18] = mk(0, 0, 32'd0,    32'd0,        0,   0, 0, 32'd0,    32'd0,        1);
    vecs[19] = mk(0, 0, 32'd0,    32'd0,        0,   0, 0, 32'd0,    32'd0,        1);

    drive(0, 0, 0, 0, 0);
    #12;
    chk_state("reset_hold", 0, 0, 32'd0, 32'd0, 1);
    @(negedge clk);
    rst = 1'b1;
    tick;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_pc, vecs[i].in_instr, vecs[i].out_ready);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_valid,
                vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_in_ready);
      tick;
    end

    // Steady push+pop at cnt=2 across several pointer wraps
    drive(0, 1, 32'h1000, 32'hB000, 0); tick;
    drive(0, 1, 32'h1004, 32'hB001, 0); tick;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h1008 + 32'(4*k), 32'hB002 + 32'(k), 1);
      #1;
      chk($sformatf("wrap%0d.count", k),  32'(qif.count), 32'd2);
      chk($sformatf("wrap%0d.out_pc", k), qif.out_pc,     32'h1000 + 32'(4*k));
      tick;
    end

    // Async reset mid-traffic with three entries queued
    drive(1, 0, 0, 0, 0); tick;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h300 + 32'(4*k), 32'hC00 + 32'(k), 0);
      tick;
    end
    drive(0, 0, 0, 0, 0);
    chk("pre_reset.count", 32'(qif.count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_reset", 0, 0, 32'd0, 32'd0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk_state("post_reset", 0, 0, 32'd0, 32'd0, 1);

    // Random traffic vs queue model
    model.delete();
    for (int c = 0; c < 400; c++) begin
      logic        fl, iv, ord, m_push, m_pop;
      logic [31:0] pc, ins;
      fl  = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      ord = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 80));
      pc  = $urandom;
      ins = $urandom;
      drive(fl, iv, pc, ins, ord);
      #1;
      chk_state($sformatf("rnd%0d", c), model.size(), model.size() != 0,
                model.size() != 0 ? model[0][63:32] : 32'd0,
                model.size() != 0 ? model[0][31:0]  : 32'd0,
                model.size() < DEPTH);
      m_push = iv && (model.size() < DEPTH) && !fl;
      m_pop  = ord && (model.size() > 0) && !fl;
      if (fl) model.delete();
      else begin
        if (m_pop)  void'(model.pop_front());
        if (m_push) model.push_back({pc, ins});
      end
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Decoupling FIFO between the instruction-fetch stage and the decode stage of the ARM pipeline.
- Captures {PC, Instruction} pairs produced by fetch and presents them in order to decode.
- Decode stalls no longer freeze fetch immediately; fetch is frozen only when the queue is full.
- A taken branch flushes all queued (wrong-path) instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PTR_W, 2, pointer width = log2(DEPTH); must match DEPTH

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low: asserting rst=0 clears all state immediately; release is synchronous to clk
- flush  input  1  branch taken (from EXE); discards all entries
- in_valid  input  1  fetch output valid this cycle
- in_pc  input  32  fetched PC+4 value from fetch stage
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue can accept; fetch freeze = ~in_ready
- out_valid  output  1  head entry valid
- out_pc  output  32  head entry PC
- out_instr  output  32  head entry instruction
- out_ready  input  1  decode consumes head this cycle (decode not frozen)
- count  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH x 64-bit array {pc, instr}, write pointer wr_ptr, read pointer rd_ptr, occupancy cnt.
- Reset (rst=0, async):
  - wr_ptr=0, rd_ptr=0, cnt=0, all storage entries = 0.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=1, count=0.
- Combinational outputs:
  - in_ready = (cnt != DEPTH). Not gated by out_ready: no full-queue bypass.
  - out_valid = (cnt != 0).
  - out_pc/out_instr = storage[rd_ptr] when cnt != 0, else 32'd0 (0 is the NOP encoding).
  - count = cnt.
- Handshake:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Per clock edge:
  - flush=1: wr_ptr<=0, rd_ptr<=0, cnt<=0. Same-cycle push and pop are both dropped. Storage contents are don't-care (not cleared).
  - push only: storage[wr_ptr]<={in_pc,in_instr}; wr_ptr<=wr_ptr+1; cnt<=cnt+1.
  - pop only: rd_ptr<=rd_ptr+1; cnt<=cnt-1.
  - push and pop: write, both pointers advance, cnt unchanged. Legal at any 0<cnt<DEPTH.
  - neither: hold.
- Latency: an entry pushed in cycle N appears at the head in cycle N+1 at the earliest. No same-cycle bypass, even when empty.
- Pointer wrap: pointers are PTR_W bits and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Full: in_ready=0; in_valid is ignored and data is not written. Fetch must hold its PC via freeze.
- Empty: out_valid=0; out_ready is ignored and cnt never underflows.
- Ordering: strict FIFO; no reordering or duplication.
- Flush recovery: after a flush the queue is empty; the first post-flush push (branch target) is at the head the following cycle.

Test Plan:
- Reset:
  - Hold rst=0 for 2 cycles mid-traffic with cnt=3.
  - Required: count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1 immediately (before any clk edge).
- Fill/full:
  - out_ready=0; push pc=4,8,12,16 with instr=0xE3A01001..0xE3A01004.
  - Required: count=4, in_ready=0.
  - A 5th push with pc=20 is ignored; the head stays pc=4 / 0xE3A01001.
- Drain order:
  - From the full state, out_ready=1, in_valid=0 for 4 cycles.
  - Required: heads pc=4, 8, 12, 16 in successive cycles; then out_valid=0, count=0.
- Simultaneous push/pop with wrap:
  - Hold cnt=2, in_valid=1, out_ready=1 for 10 cycles with pc incrementing by 4.
  - Required: count stays 2; output pc sequence is continuous across pointer wrap, with no gaps or duplicates.
- Flush priority:
  - cnt=3, with flush=1, in_valid=1 (pc=0x100) and out_ready=1 in the same cycle.
  - Required next cycle: count=0, out_valid=0, pc 0x100 not stored.
  - Then push pc=0x200 -> out_pc=0x200 with out_valid=1 on the following cycle.
- Empty latency:
  - Empty queue, push pc=0x40 with out_ready=1.
  - Required: out_valid=0 in the push cycle; out_valid=1 with out_pc=0x40 the next cycle; popped that cycle, count returns to 0.
